// File: rtl/dbg_apb_pkg.sv
// Shared types for the debug APB master: response codes, FSM states and the
// one-hot slave-select helper used by the address decoder.
package dbg_apb_pkg;

    localparam int MAX_SLAVES = 16;

    typedef enum logic [1:0] {
        OKAY    = 2'd0,
        TIMEOUT = 2'd1,
        DECERR  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Indices at or beyond n yield an all-zero select.
    function automatic logic [MAX_SLAVES-1:0] onehot_sel(input logic [3:0] idx, input int n);
        logic [MAX_SLAVES-1:0] v;
        v = '0;
        if (int'(idx) < n) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dbg_apb_decode.sv
// Combinational APB address decoder: slave index field -> one-hot select and
// decode-error flag. Kept separate so other bus masters can share it.
module dbg_apb_decode
    import dbg_apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int NR_SLAVES   = 4,
    parameter int SLAVE_SHIFT = 12
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [NR_SLAVES-1:0]  o_sel,
    output logic                  o_dec_err
);

    localparam int SIDX_W = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;

    logic [SIDX_W-1:0]     w_idx;
    logic [MAX_SLAVES-1:0] w_hot;
    logic                  w_unused_bits;

    assign w_idx     = i_addr[SLAVE_SHIFT +: SIDX_W];
    assign w_hot     = onehot_sel(4'(w_idx), NR_SLAVES);
    assign o_sel     = w_hot[NR_SLAVES-1:0];
    assign o_dec_err = (32'(w_idx) >= NR_SLAVES);

    // Only the index field and the low select bits matter; fold the rest away.
    assign w_unused_bits = ^{i_addr, w_hot};

endmodule

// File: rtl/dbg_apb_master.sv
// APB master bridging JTAG debug TAP transactions onto the debug APB bus:
// request capture, address decode, SETUP/ACCESS sequencing with timeout, response.
module dbg_apb_master
    import dbg_apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NR_SLAVES   = 4,
    parameter int SLAVE_SHIFT = 12,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output resp_e                   rsp_code,

    output logic [ADDR_WIDTH-1:0]   apb_addr,
    output logic [NR_SLAVES-1:0]    apb_sel,
    output logic                    apb_write,
    output logic [DATA_WIDTH-1:0]   apb_wdata,
    output logic [DATA_WIDTH/8-1:0] apb_wstrb,
    input  logic                    apb_enable,
    input  logic                    apb_ready,
    input  logic [DATA_WIDTH-1:0]   apb_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0]            r_state;
    logic [NR_SLAVES-1:0]  r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    resp_e                 r_code;
    logic [CNT_W-1:0]      r_cnt;

    logic [NR_SLAVES-1:0]  w_dec_sel;
    logic                  w_dec_err;

    dbg_apb_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NR_SLAVES   (NR_SLAVES),
        .SLAVE_SHIFT (SLAVE_SHIFT)
    ) u_decode (
        .i_addr    (req_addr),
        .o_sel     (w_dec_sel),
        .o_dec_err (w_dec_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_code      <= OKAY;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        r_cnt   <= '0;
                        if (w_dec_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= '0;
                            r_code      <= DECERR;
                        end else begin
                            r_state <= S_SETUP;
                            r_sel   <= w_dec_sel;
                        end
                    end
                end
                // The bus owns the ACCESS phase: only cycles with apb_enable count
                // toward the timeout, and a ready slave always beats the timeout.
                S_SETUP, S_ACCESS: begin
                    if (apb_enable) begin
                        if (apb_ready) begin
                            r_state     <= S_RESP;
                            r_sel       <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= r_write ? '0 : apb_rdata;
                            r_code      <= OKAY;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state     <= S_RESP;
                            r_sel       <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= '0;
                            r_code      <= dbg_apb_pkg::TIMEOUT;
                        end else begin
                            r_state <= S_ACCESS;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sel       <= '0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_code  = r_code;
    assign apb_addr  = r_addr;
    assign apb_sel   = r_sel;
    assign apb_write = r_write;
    assign apb_wdata = r_wdata;
    assign apb_wstrb = r_wstrb;

endmodule

// File: tb/tb_dbg_apb_master.sv
// Directed bench for dbg_apb_master: a configurable wait-state slave, a response
// scoreboard, and a second 3-slave instance for the decode-error path.
module tb_dbg_apb_master;
    import dbg_apb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, apb_write, apb_enable, apb_ready;
    logic [31:0] rsp_rdata, apb_addr, apb_wdata, apb_rdata;
    resp_e       rsp_code;
    logic [3:0]  apb_sel, apb_wstrb;

    logic        d3_req_valid = 1'b0, d3_req_write = 1'b0, d3_rsp_ready = 1'b0;
    logic [31:0] d3_req_addr = '0, d3_req_wdata = '0;
    logic [3:0]  d3_req_wstrb = '0;
    logic        d3_req_ready, d3_rsp_valid, d3_apb_write;
    logic        d3_apb_enable = 1'b0, d3_apb_ready = 1'b0;
    logic [31:0] d3_rsp_rdata, d3_apb_addr, d3_apb_wdata;
    logic [31:0] d3_apb_rdata = 32'h1357_9BDF;
    resp_e       d3_rsp_code;
    logic [2:0]  d3_apb_sel;
    logic [3:0]  d3_apb_wstrb;

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] sb[$];
    int          wait_states = 0;
    logic [31:0] slave_data = '0;
    logic        bus_en = 1'b0;
    int          bus_wait = 0;
    logic        sel3_seen = 1'b0;

    always #5 clk = ~clk;

    dbg_apb_master #(.NR_SLAVES(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
        .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_write(apb_write), .apb_wdata(apb_wdata),
        .apb_wstrb(apb_wstrb), .apb_enable(apb_enable), .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    dbg_apb_master #(.NR_SLAVES(3), .TIMEOUT(255)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(d3_req_write),
        .req_addr(d3_req_addr), .req_wdata(d3_req_wdata), .req_wstrb(d3_req_wstrb),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_rdata(d3_rsp_rdata),
        .rsp_code(d3_rsp_code),
        .apb_addr(d3_apb_addr), .apb_sel(d3_apb_sel), .apb_write(d3_apb_write),
        .apb_wdata(d3_apb_wdata), .apb_wstrb(d3_apb_wstrb), .apb_enable(d3_apb_enable),
        .apb_ready(d3_apb_ready), .apb_rdata(d3_apb_rdata)
    );

    // Interconnect model: enable follows the first select cycle, ready after wait_states.
    always @(posedge clk) begin
        if (!rst_n || apb_sel == '0) begin
            bus_en   <= 1'b0;
            bus_wait <= 0;
        end else if (!bus_en) begin
            bus_en   <= 1'b1;
            bus_wait <= 0;
        end else begin
            bus_wait <= bus_wait + 1;
        end
    end

    assign apb_enable = bus_en && (apb_sel != '0);
    assign apb_ready  = apb_enable && (bus_wait >= wait_states);
    assign apb_rdata  = slave_data;

    always @(posedge clk) begin
        if (rst_n && d3_apb_sel != '0) sel3_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ":rsp_valid"}, rsp_valid, 0);
        chk({tag, ":apb_sel"},   apb_sel,   0);
        chk({tag, ":apb_write"}, apb_write, 0);
        chk({tag, ":apb_addr"},  apb_addr,  0);
        chk({tag, ":apb_wdata"}, apb_wdata, 0);
        chk({tag, ":apb_wstrb"}, apb_wstrb, 0);
        chk({tag, ":rsp_rdata"}, rsp_rdata, 0);
        chk({tag, ":rsp_code"},  rsp_code,  OKAY);
        chk({tag, ":req_ready"}, req_ready, 1);
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int ws,
                           input logic [31:0] sdata, input logic [3:0] exp_sel,
                           input int exp_selcyc, input int exp_lat, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_code, input int stall);
        int          lat;
        int          selcyc;
        logic [3:0]  first_sel;
        logic [33:0] exp;
        logic        stable;
        logic [31:0] held_rdata;
        logic [1:0]  held_code;
        wait_states = ws;
        slave_data  = sdata;
        sb.push_back({exp_code, exp_rdata});
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
        rsp_ready = 1'b0;
        chk({tag, ":req_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        lat = 1; selcyc = 0; first_sel = '0;
        while (!rsp_valid && lat <= 600) begin
            if (apb_sel != '0) begin
                if (selcyc == 0) begin
                    first_sel = apb_sel;
                    chk({tag, ":apb_addr"},  apb_addr,  addr);
                    chk({tag, ":apb_write"}, apb_write, wr);
                    chk({tag, ":apb_wdata"}, apb_wdata, data);
                    chk({tag, ":apb_wstrb"}, apb_wstrb, strb);
                end
                selcyc++;
            end
            tick();
            lat++;
        end
        chk({tag, ":latency"},     lat,       exp_lat);
        chk({tag, ":sel_cycles"},  selcyc,    exp_selcyc);
        chk({tag, ":sel_onehot"},  first_sel, exp_sel);
        chk({tag, ":sel_dropped"}, apb_sel,   0);
        chk({tag, ":addr_kept"},   apb_addr,  addr);
        if (sb.size() == 0) begin
            chk({tag, ":sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            chk({tag, ":rsp_rdata"}, rsp_rdata, exp[31:0]);
            chk({tag, ":rsp_code"},  rsp_code,  exp[33:32]);
        end
        held_rdata = rsp_rdata;
        held_code  = rsp_code;
        stable     = 1'b1;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1FF0;
            tick();
            if (!rsp_valid || rsp_rdata !== held_rdata || rsp_code !== held_code ||
                req_ready !== 1'b0 || apb_sel !== '0 || apb_addr !== addr)
                stable = 1'b0;
        end
        if (stall > 0) chk({tag, ":stall_stable"}, stable, 1);
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk({tag, ":rsp_drained"},   rsp_valid, 0);
        chk({tag, ":idle_after"},    req_ready, 1);
    endtask

    initial begin
        logic [33:0] exp3;

        rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_values("reset");
        chk("reset:d3_rsp_valid", d3_rsp_valid, 0);
        rst_n = 1'b1;
        tick();

        run_txn("wr_s1", 1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 0, 32'h1234_5678,
                4'b0010, 2, 3, 32'h0, OKAY, 0);
        run_txn("rd_s2_ws3", 1'b0, 32'h0000_2000, 32'h0, 4'h0, 3, 32'hDEAD_BEEF,
                4'b0100, 5, 6, 32'hDEAD_BEEF, OKAY, 0);
        run_txn("wr_s3_strb", 1'b1, 32'h0000_3010, 32'h0BAD_F00D, 4'h3, 1, 32'hFFFF_FFFF,
                4'b1000, 3, 4, 32'h0, OKAY, 0);
        run_txn("rd_timeout", 1'b0, 32'h0000_0040, 32'h0, 4'h0, 100000, 32'h5555_AAAA,
                4'b0001, 256, 257, 32'h0, dbg_apb_pkg::TIMEOUT, 0);
        run_txn("rd_ready_at_limit", 1'b0, 32'h0000_1100, 32'h0, 4'h0, 254, 32'h0F0F_1234,
                4'b0010, 256, 257, 32'h0F0F_1234, OKAY, 0);
        run_txn("rd_stall", 1'b0, 32'h0000_2008, 32'h0, 4'h0, 0, 32'h7777_0001,
                4'b0100, 2, 3, 32'h7777_0001, OKAY, 10);
        run_txn("wr_after_drain", 1'b1, 32'h0000_0004, 32'hCAFE_0000, 4'hC, 0, 32'h0,
                4'b0001, 2, 3, 32'h0, OKAY, 0);

        // Reset in the middle of an ACCESS phase with a stalled slave.
        wait_states = 100000;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("rst_mid:sel_active", apb_sel, 4'b1000);
        rst_n = 1'b0;
        tick();
        chk_reset_values("rst_mid");
        rst_n = 1'b1;
        tick();
        run_txn("wr_after_reset", 1'b1, 32'h0000_1008, 32'h0102_0304, 4'hF, 0, 32'h0,
                4'b0010, 2, 3, 32'h0, OKAY, 0);

        // Decode error on the 3-slave instance: index 3 has no slave.
        sb.push_back({DECERR, 32'h0});
        d3_req_valid = 1'b1; d3_req_write = 1'b0; d3_req_addr = 32'h0000_3000;
        chk("decerr:req_ready", d3_req_ready, 1);
        tick();
        d3_req_valid = 1'b0;
        chk("decerr:latency1", d3_rsp_valid, 1);
        if (sb.size() == 0) begin
            chk("decerr:sb_empty", 1, 0);
        end else begin
            exp3 = sb.pop_front();
            chk("decerr:rsp_code",  d3_rsp_code,  exp3[33:32]);
            chk("decerr:rsp_rdata", d3_rsp_rdata, exp3[31:0]);
        end
        chk("decerr:req_ready_busy", d3_req_ready, 0);
        d3_rsp_ready = 1'b1;
        tick();
        d3_rsp_ready = 1'b0;
        chk("decerr:drained", d3_rsp_valid, 0);
        tick();
        chk("decerr:sel_never", sel3_seen, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
